flick_tick_bank: RTL and testbench
==================================

FLICK_TICK_BANK -- requirements
Module: flick_tick_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent tick channels, range 1..16.
REQ-002 Parameter CNT_W, default 21: divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default 250000: divisor loaded into every channel at reset; must fit in CNT_W bits.
REQ-004 Derived constant CH_W = max(1, ceil(log2(N_CH))): width of the channel-select field.
REQ-005 clk_2MHz  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ch_en  in  N_CH  per-channel count enable, level-sensitive.
REQ-008 sync  in  1  one-cycle pulse; restarts the phase of all channels.
REQ-009 load  in  1  one-cycle pulse; writes load_div and load_mode into channel load_ch.
REQ-010 load_ch  in  CH_W  target channel of load; values >= N_CH are ignored (no write occurs).
REQ-011 load_div  in  CNT_W  new divisor for the target channel.
REQ-012 load_mode  in  1  new mode for the target channel: 0 = free-running, 1 = one-shot.
REQ-013 tick  out  N_CH  registered one-cycle pulse at each terminal count, per channel.
REQ-014 wave  out  N_CH  registered square output; toggles at each terminal count, per channel.
REQ-015 done  out  N_CH  registered sticky flag; set when a one-shot channel completes.

Function
REQ-016 Each channel SHALL hold the registers div (CNT_W bits), mode (1 bit), cnt (CNT_W bits), wave, tick, and done.
REQ-017 Active condition: ch_en[i]=1, div!=0, and not (mode=1 and done=1).
REQ-018 When active and cnt != div-1, the channel SHALL update cnt <= cnt+1 and tick <= 0.
REQ-019 When active and cnt == div-1 (terminal count), the channel SHALL update cnt <= 0, tick <= 1 for one cycle, and wave <= ~wave.
- Tick period is div cycles; wave period is 2*div cycles.
- With cnt=0 at enable, the first tick is high in the cycle after rising edge number div.
REQ-020 div=1: tick SHALL be high every cycle and wave SHALL toggle every cycle.
REQ-021 div=0: the channel is stopped; cnt, wave, and done hold; tick=0.
REQ-022 When not active, cnt, wave, and done SHALL hold and tick SHALL be 0.
REQ-023 One-shot (mode=1): at the first terminal count after start, the channel SHALL set done <= 1, set tick <= 1, toggle wave, and stop counting.
REQ-024 One-shot restart: only load to that channel, sync, or reset SHALL restart a one-shot channel.
REQ-025 load with a valid load_ch SHALL, at the next edge, set that channel's div <= load_div, mode <= load_mode, cnt <= 0, wave <= 0, done <= 0, tick <= 0.
- load overrides a terminal count on that channel in the same cycle: no tick, no toggle.
REQ-026 sync SHALL, at the next edge, set cnt <= 0, wave <= 0, done <= 0, and tick <= 0 on all channels; div and mode are unchanged.
- sync overrides terminal counts on all channels.
REQ-027 sync and load in the same cycle: both SHALL apply; the loaded channel takes the new div and mode, and all channels restart.
REQ-028 Changing ch_en mid-period SHALL pause the count with cnt preserved; re-enabling resumes from the preserved cnt.
REQ-029 cnt SHALL never exceed div-1.
- If cnt >= div through any path, it SHALL be treated as terminal count on the next active cycle.
REQ-030 Counter arithmetic is unsigned CNT_W-bit with no carry out; no wrap-around is reachable given REQ-029.
REQ-031 Channels SHALL be fully independent; activity on channel i SHALL not alter the state of channel j.

Reset
REQ-032 While reset=1, asynchronously for every channel: div=DEF_DIV, mode=0, cnt=0, wave=0, tick=0, done=0.
REQ-033 After reset deasserts, counting SHALL begin on the first rising edge at which the channel is active.
REQ-034 Reset asserted mid-period or mid-load SHALL discard all in-flight state; no tick SHALL be emitted after reset.

Verification (bench configuration: N_CH=4, CNT_W=8, DEF_DIV=5)
REQ-035 Reset, then ch_en=4'b0001 -> tick[0] high every 5th cycle; wave[0] toggles every 5 cycles; channels 1-3 stay at 0.
REQ-036 Load ch2 with div=3, mode=1, then ch_en[2]=1 -> exactly one tick[2], 3 cycles after the load edge; done[2]=1 and wave[2]=1 hold afterwards.
REQ-037 Load ch1 with div=1 -> tick[1] high continuously; wave[1] alternates every cycle; then load div=0 -> tick[1]=0 and wave[1] frozen at 0.
REQ-038 Assert load ch0 with div=4 in the cycle where ch0 cnt=4 (terminal count) -> no tick in that cycle, cnt=0, next tick 4 cycles later.
REQ-039 All channels running, pulse sync together with load of ch3 (div=2) -> all cnt=0 and wave=0; ch3 ticks every 2 cycles, the others every 5.
REQ-040 Assert reset for 1 cycle mid-period with ch0 at cnt=3 -> all outputs 0 at once; ch0 next ticks 5 cycles after reset release.

Source files
------------

// File: rtl/flick_tick_bank.sv
// -----------------------------------------------------------------------------
// flick_tick_bank
//
// A bank of N_CH independent programmable tick generators on the 2 MHz clock.
// Each channel counts clk_2MHz edges up to its own divisor. At every terminal
// count it emits a one-cycle tick pulse and toggles a square wave output.
// A channel is either free-running (mode 0) or one-shot (mode 1). A one-shot
// channel stops after its first terminal count and raises a sticky done flag.
//
// Parameters
//   N_CH     number of channels, 1..16
//   CNT_W    divisor / counter width in bits
//   DEF_DIV  divisor loaded into every channel by reset (must fit in CNT_W)
//
// Ports
//   clk_2MHz   in   1      system clock, all state changes on the rising edge
//   reset      in   1      asynchronous, active-high reset
//   ch_en      in   N_CH   per-channel count enable (level)
//   sync       in   1      one-cycle pulse: restart the phase of every channel
//   load       in   1      one-cycle pulse: write load_div/load_mode to load_ch
//   load_ch    in   CH_W   target channel of load; values >= N_CH write nothing
//   load_div   in   CNT_W  new divisor (0 stops the channel)
//   load_mode  in   1      new mode: 0 = free-running, 1 = one-shot
//   tick       out  N_CH   registered one-cycle pulse at each terminal count
//   wave       out  N_CH   registered square wave, toggles at each terminal count
//   done       out  N_CH   registered sticky flag, set when a one-shot completes
// -----------------------------------------------------------------------------
module flick_tick_bank #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 21,
  parameter int unsigned DEF_DIV = 250000,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_2MHz,
  input  logic             reset,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync,
  input  logic             load,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_mode,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  wave,
  output logic [N_CH-1:0]  done
);

  // Reset value of the divisor, sized once so every channel uses the same
  // constant without repeating the width cast.
  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  // Operating mode of a channel.
  typedef enum logic {
    MODE_FREE    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  // Complete architectural state of one channel. Keeping it in a single
  // struct makes reset, restart and load read as whole-state assignments.
  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    mode_e            mode;
    logic             wave;
    logic             tick;
    logic             done;
  } chan_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch

    chan_t            st_q;
    logic             load_hit;
    logic             active;
    logic             terminal;
    logic [CNT_W-1:0] div_m1;

    // A load addresses this channel only when load_ch equals its index.
    // Codes >= N_CH match no channel, so an out-of-range load writes nothing.
    assign load_hit = load && (load_ch == CH_W'(i));

    // div == 0 parks the channel. A one-shot that has completed also parks
    // until a load, a sync or a reset restarts it.
    assign active = ch_en[i]
                 && (st_q.div != '0)
                 && !((st_q.mode == MODE_ONESHOT) && st_q.done);

    // Terminal count uses >= instead of == so that a counter sitting at or
    // above div-1 cannot run on towards wrap-around. It simply terminates on
    // the next active cycle. div_m1 is only consulted while div != 0, so the
    // underflow for div == 0 never matters.
    assign div_m1   = st_q.div - CNT_W'(1);
    assign terminal = (st_q.cnt >= div_m1);

    // NOTE: sequential state is assigned with non-blocking (<=) only, so every
    //       channel register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_2MHz or posedge reset) begin
      if (reset) begin
        st_q.div  <= DEF_DIV_W;
        st_q.cnt  <= '0;
        st_q.mode <= MODE_FREE;
        st_q.wave <= 1'b0;
        st_q.tick <= 1'b0;
        st_q.done <= 1'b0;
      end else if (sync || load_hit) begin
        // A restart outranks a terminal count in the same cycle: no tick and
        // no toggle. When sync and load coincide, the addressed channel takes
        // its new divisor and mode while every channel restarts.
        st_q.cnt  <= '0;
        st_q.wave <= 1'b0;
        st_q.tick <= 1'b0;
        st_q.done <= 1'b0;
        if (load_hit) begin
          st_q.div  <= load_div;
          st_q.mode <= mode_e'(load_mode);
        end
      end else if (active) begin
        if (terminal) begin
          st_q.cnt  <= '0;
          st_q.tick <= 1'b1;
          st_q.wave <= ~st_q.wave;
          // Only a one-shot latches done. A free-running channel keeps done
          // at its cleared value.
          if (st_q.mode == MODE_ONESHOT) begin
            st_q.done <= 1'b1;
          end
        end else begin
          st_q.cnt  <= st_q.cnt + CNT_W'(1);
          st_q.tick <= 1'b0;
        end
      end else begin
        // Paused, stopped (div == 0) or finished one-shot. cnt, wave and done
        // hold so that re-enabling resumes mid-period.
        st_q.tick <= 1'b0;
      end
    end

    assign tick[i] = st_q.tick;
    assign wave[i] = st_q.wave;
    assign done[i] = st_q.done;

  end : g_ch

endmodule : flick_tick_bank

// File: tb/tb_flick_tick_bank.sv
// -----------------------------------------------------------------------------
// tb_flick_tick_bank
//
// Self-checking bench for flick_tick_bank (N_CH=4, CNT_W=8, DEF_DIV=5).
// A table of per-cycle records {inputs, expected tick/wave/done} is built
// first. Each record is driven on the falling edge and its expectation is
// pushed to a scoreboard queue. The expectation is popped and compared on the
// following falling edge, after the rising edge the record was applied to.
// Reset is one of the table inputs, so reset scenarios share the same loop.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_flick_tick_bank;

  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 5;

  logic             clk_2MHz = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  ch_en;
  logic             sync;
  logic             load;
  logic [1:0]       load_ch;
  logic [CNT_W-1:0] load_div;
  logic             load_mode;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  wave;
  logic [N_CH-1:0]  done;

  flick_tick_bank #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk_2MHz  (clk_2MHz),
    .reset     (reset),
    .ch_en     (ch_en),
    .sync      (sync),
    .load      (load),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .load_mode (load_mode),
    .tick      (tick),
    .wave      (wave),
    .done      (done)
  );

  // 2 MHz clock: 500 ns period.
  always #250 clk_2MHz = ~clk_2MHz;

  typedef struct {
    logic             rst;
    logic [N_CH-1:0]  en;
    logic             syn;
    logic             ld;
    logic [1:0]       lch;
    logic [CNT_W-1:0] ldiv;
    logic             lmode;
    logic [N_CH-1:0]  e_tick;
    logic [N_CH-1:0]  e_wave;
    logic [N_CH-1:0]  e_done;
    string            tag;
  } vec_t;

  typedef struct {
    logic [3*N_CH-1:0] outs;   // {tick, wave, done}
    string             tag;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [3*N_CH-1:0] act,
                       input logic [3*N_CH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got tick/wave/done=%b_%b_%b need %b_%b_%b", name,
               act[3*N_CH-1 -: N_CH], act[2*N_CH-1 -: N_CH], act[N_CH-1:0],
               req[3*N_CH-1 -: N_CH], req[2*N_CH-1 -: N_CH], req[N_CH-1:0]);
    end
  endtask

  function automatic void add(input logic r, input logic [N_CH-1:0] en,
                              input logic s, input logic l, input logic [1:0] lc,
                              input logic [CNT_W-1:0] ld, input logic lm,
                              input logic [N_CH-1:0] et, input logic [N_CH-1:0] ew,
                              input logic [N_CH-1:0] ed, input string tag);
    vec_t v;
    v.rst = r; v.en = en; v.syn = s; v.ld = l; v.lch = lc; v.ldiv = ld;
    v.lmode = lm; v.e_tick = et; v.e_wave = ew; v.e_done = ed; v.tag = tag;
    tab.push_back(v);
  endfunction

  // Plain counting cycle: only ch_en driven.
  function automatic void run(input logic [N_CH-1:0] en, input logic [N_CH-1:0] et,
                              input logic [N_CH-1:0] ew, input logic [N_CH-1:0] ed,
                              input string tag);
    add(1'b0, en, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, et, ew, ed, tag);
  endfunction

  function automatic void rst_vec(input logic [N_CH-1:0] en, input string tag);
    add(1'b1, en, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0, 4'b0, 4'b0, tag);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    reset     = v.rst;
    ch_en     = v.en;
    sync      = v.syn;
    load      = v.ld;
    load_ch   = v.lch;
    load_div  = v.ldiv;
    load_mode = v.lmode;
    e.outs = {v.e_tick, v.e_wave, v.e_done};
    e.tag  = v.tag;
    sb.push_back(e);
    // Reset is asynchronous: outputs must clear before any clock edge.
    if (v.rst) begin
      #1;
      check({v.tag, "_async"}, {tick, wave, done}, '0);
    end
  endtask

  task automatic compare_one();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries need >=1");
    end else begin
      e = sb.pop_front();
      check(e.tag, {tick, wave, done}, e.outs);
    end
  endtask

  // Guards against a stalled run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       t, w, d, t3, w3;
    int         a;

    reset = 1'b1; ch_en = '0; sync = 1'b0; load = 1'b0;
    load_ch = '0; load_div = '0; load_mode = 1'b0;

    // --- Default divisor 5 on ch0, pause and resume -------------------------
    rst_vec(4'b0000, "A_rst");
    a = 0;
    for (int k = 1; k <= 12; k++) begin
      a++;
      t = (a % 5 == 0); w = ((a / 5) % 2 == 1);
      run(4'b0001, {3'b0, t}, {3'b0, w}, 4'b0, $sformatf("A_run%0d", k));
    end
    // Pause with cnt=2, wave=0: nothing moves.
    for (int k = 1; k <= 3; k++)
      run(4'b0000, 4'b0, {3'b0, w}, 4'b0, $sformatf("A_pause%0d", k));
    // Resume: the count continues from 2, so the next tick is 3 edges away.
    for (int k = 1; k <= 5; k++) begin
      a++;
      t = (a % 5 == 0); w = ((a / 5) % 2 == 1);
      run(4'b0001, {3'b0, t}, {3'b0, w}, 4'b0, $sformatf("A_resume%0d", k));
    end

    // --- One-shot on ch2, div=3, then restart by sync ------------------------
    rst_vec(4'b0000, "B_rst");
    add(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 8'd3, 1'b1, 4'b0, 4'b0, 4'b0, "B_load");
    for (int k = 1; k <= 8; k++) begin
      t = (k == 3); d = (k >= 3);
      run(4'b0100, {1'b0, t, 2'b0}, {1'b0, d, 2'b0}, {1'b0, d, 2'b0},
          $sformatf("B_shot%0d", k));
    end
    add(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0, 4'b0, 4'b0, "B_sync");
    for (int k = 1; k <= 5; k++) begin
      t = (k == 3); d = (k >= 3);
      run(4'b0100, {1'b0, t, 2'b0}, {1'b0, d, 2'b0}, {1'b0, d, 2'b0},
          $sformatf("B_reshot%0d", k));
    end

    // --- ch1 div=1 (tick every cycle), then div=0 (stopped) ------------------
    rst_vec(4'b0000, "C_rst");
    add(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0, 4'b0, 4'b0, 4'b0, "C_load1");
    for (int k = 1; k <= 6; k++) begin
      w = (k % 2 == 1);
      run(4'b0010, 4'b0010, {2'b0, w, 1'b0}, 4'b0, $sformatf("C_div1_%0d", k));
    end
    add(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 8'd0, 1'b0, 4'b0, 4'b0, 4'b0, "C_load0");
    for (int k = 1; k <= 4; k++)
      run(4'b0010, 4'b0, 4'b0, 4'b0, $sformatf("C_div0_%0d", k));

    // --- Load ch0 div=4 exactly on its terminal-count cycle ------------------
    rst_vec(4'b0000, "D_rst");
    for (int k = 1; k <= 4; k++)
      run(4'b0001, 4'b0, 4'b0, 4'b0, $sformatf("D_pre%0d", k));
    add(1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 8'd4, 1'b0, 4'b0, 4'b0, 4'b0, "D_load_tc");
    for (int k = 1; k <= 6; k++) begin
      t = (k == 4); w = (k >= 4);
      run(4'b0001, {3'b0, t}, {3'b0, w}, 4'b0, $sformatf("D_post%0d", k));
    end

    // --- All channels, sync together with load ch3 div=2 ---------------------
    rst_vec(4'b0000, "E_rst");
    for (int k = 1; k <= 7; k++) begin
      t = (k == 5); w = (k >= 5);
      run(4'b1111, {4{t}}, {4{w}}, 4'b0, $sformatf("E_pre%0d", k));
    end
    add(1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 8'd2, 1'b0, 4'b0, 4'b0, 4'b0, "E_sync_load");
    for (int k = 1; k <= 10; k++) begin
      t  = (k % 5 == 0); w  = ((k / 5) % 2 == 1);
      t3 = (k % 2 == 0); w3 = ((k / 2) % 2 == 1);
      run(4'b1111, {t3, t, t, t}, {w3, w, w, w}, 4'b0, $sformatf("E_post%0d", k));
    end

    // --- Reset mid-period (ch0 cnt=3, wave=1) --------------------------------
    rst_vec(4'b0000, "F_rst0");
    for (int k = 1; k <= 8; k++) begin
      t = (k == 5); w = (k >= 5);
      run(4'b0001, {3'b0, t}, {3'b0, w}, 4'b0, $sformatf("F_pre%0d", k));
    end
    rst_vec(4'b0001, "F_rst_mid");
    for (int k = 1; k <= 7; k++) begin
      t = (k == 5); w = (k >= 5);
      run(4'b0001, {3'b0, t}, {3'b0, w}, 4'b0, $sformatf("F_post%0d", k));
    end

    // --- Drive the table -----------------------------------------------------
    @(negedge clk_2MHz);
    for (int i = 0; i < tab.size(); i++) begin
      if (i > 0) compare_one();
      apply(tab[i]);
      @(negedge clk_2MHz);
    end
    compare_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_flick_tick_bank
